// File: rtl/odu_chan_arb_mux.sv
// Round-robin, burst-limited N-channel FIFO read arbiter and output mux with channel-ID tagging.
// Optional statistics counters are built only when ODU_ARB_STATS_EN is defined.
module odu_chan_arb_mux #(
  parameter int NUM_CH    = 80,
  parameter int DATA_W    = 395,
  parameter int CHID_W    = 7,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [NUM_CH-1:0]        fifo_empty,
  input  logic [NUM_CH*DATA_W-1:0] fifo_data,
  output logic [NUM_CH-1:0]        fifo_rd_en,
  output logic [DATA_W-1:0]        data_out,
  output logic [CHID_W-1:0]        chid_out,
  output logic                     data_valid,
  input  logic                     data_ready,
  output logic [31:0]              stat_word_cnt,
  output logic [31:0]              stat_stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_RD,
    S_CAP,
    S_WAIT
  } state_t;

  state_t              state, state_d;
  logic [CHID_W-1:0]   ptr, ptr_d;
  logic [CHID_W-1:0]   sel, sel_d;
  logic [3:0]          burst_cnt, burst_d;
  logic [CHID_W-1:0]   arb_sel;
  logic                arb_found;
  logic [NUM_CH-1:0]   elig;
  logic                xfer;
  int                  idx;
  logic [CHID_W-1:0]   cand;
  logic [DATA_W-1:0]   fifo_word [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_word
    assign fifo_word[g] = fifo_data[g*DATA_W +: DATA_W];
  end

  assign elig = ch_mask & ~fifo_empty & {NUM_CH{start}};

  // Handshake: a word moves when data_valid & data_ready in the same cycle; once raised,
  // data_valid and its payload stay unchanged until that cycle. data_ready only feeds next state.
  assign xfer = data_valid & data_ready;

  // Search ptr+1 .. NUM_CH-1, 0 .. ptr; the current pointer is tried last.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = ptr;
    idx       = 0;
    cand      = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = CHID_W'(idx);
      if (!arb_found && elig[cand]) begin
        arb_found = 1'b1;
        arb_sel   = cand;
      end
    end
  end

  always_comb begin
    state_d = state;
    sel_d   = sel;
    ptr_d   = ptr;
    burst_d = burst_cnt;
    case (state)
      S_IDLE: if (start) state_d = S_ARB;
      S_ARB: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (arb_found) begin
          sel_d   = arb_sel;
          burst_d = '0;
          state_d = S_RD;
        end
      end
      S_RD:  state_d = S_CAP;
      S_CAP: begin
        burst_d = burst_cnt + 4'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (xfer) begin
          // Empty flag and mask of the granted channel are re-checked only here.
          if (burst_cnt < 4'(MAX_BURST) && elig[sel]) begin
            state_d = S_RD;
          end else begin
            ptr_d   = sel;
            state_d = start ? S_ARB : S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      ptr       <= CHID_W'(NUM_CH - 1);
      sel       <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      sel       <= sel_d;
      burst_cnt <= burst_d;
    end
  end

  always_comb begin
    fifo_rd_en = '0;
    if (state == S_RD) fifo_rd_en[sel] = 1'b1;
  end

  // FIFO read latency is one cycle, so the word is present during CAP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out   <= '0;
      chid_out   <= '0;
      data_valid <= 1'b0;
    end else if (state == S_CAP) begin
      data_out   <= fifo_word[sel];
      chid_out   <= sel;
      data_valid <= 1'b1;
    end else if (xfer) begin
      data_valid <= 1'b0;
    end
  end

`ifdef ODU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_word_cnt  <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (xfer && stat_word_cnt != 32'hFFFF_FFFF)
        stat_word_cnt <= stat_word_cnt + 32'd1;
      if (data_valid && !data_ready && stat_stall_cnt != 32'hFFFF_FFFF)
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`else
  assign stat_word_cnt  = 32'd0;
  assign stat_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_odu_chan_arb_mux.sv
// Directed bench for odu_chan_arb_mux: FIFO model, transaction scoreboard, timing and stats checks.
module tb_odu_chan_arb_mux;
  localparam int NUM_CH    = 80;
  localparam int DATA_W    = 395;
  localparam int CHID_W    = 7;
  localparam int MAX_BURST = 4;
  localparam int W         = CHID_W + DATA_W;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [NUM_CH-1:0]        ch_mask;
  logic [NUM_CH-1:0]        fifo_empty;
  logic [NUM_CH*DATA_W-1:0] fifo_data;
  logic [NUM_CH-1:0]        fifo_rd_en;
  logic [DATA_W-1:0]        data_out;
  logic [CHID_W-1:0]        chid_out;
  logic                     data_valid;
  logic                     data_ready;
  logic [31:0]              stat_word_cnt;
  logic [31:0]              stat_stall_cnt;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // FIFO model: loaded[] owned by stimulus, reads[] owned by the monitor.
  int                loaded [NUM_CH];
  int                reads  [NUM_CH];
  logic [DATA_W-1:0] fifo_dout [NUM_CH];

  // Reference-model state owned by stimulus.
  int m_base [NUM_CH];
  int m_seq  [NUM_CH];
  int m_cnt  [NUM_CH];

  logic [W-1:0] exp_q[$];
  int           hs_cyc[$];
  int           rd_cyc[$];

  odu_chan_arb_mux #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CHID_W(CHID_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
    .data_out(data_out), .chid_out(chid_out), .data_valid(data_valid),
    .data_ready(data_ready), .stat_word_cnt(stat_word_cnt), .stat_stall_cnt(stat_stall_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fd
    assign fifo_data[g*DATA_W +: DATA_W] = fifo_dout[g];
  end

  always_comb begin
    fifo_empty = '0;
    for (int i = 0; i < NUM_CH; i++) fifo_empty[i] = (loaded[i] == reads[i]);
  end

  function automatic logic [DATA_W-1:0] make_word(input int ch, input int seq);
    logic [DATA_W-1:0] w;
    logic [31:0]       h;
    h = (32'h9e3779b9 * 32'(ch + 1)) ^ (32'(seq) * 32'h85ebca6b);
    w = DATA_W'({13{h}});
    w[15:0]  = seq[15:0];
    w[23:16] = ch[7:0];
    return w;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic         prev_valid;
    logic         prev_hs;
    logic [W-1:0] prev_bus;
    logic         hs;
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
    prev_bus   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      reads[i]     = 0;
      fifo_dout[i] = '0;
    end
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
      end else begin
        if (|fifo_rd_en) begin
          chk("rd_onehot", $countones(fifo_rd_en), 1);
          rd_cyc.push_back(cyc);
          for (int i = 0; i < NUM_CH; i++) begin
            if (fifo_rd_en[i]) begin
              chk("rd_nonempty", fifo_empty[i], 0);
              fifo_dout[i] = make_word(i, reads[i]);
              reads[i]     = reads[i] + 1;
            end
          end
        end
        if (prev_valid && !prev_hs) begin
          chk("hold_valid", data_valid, 1);
          chk("hold_payload", {chid_out, data_out}, prev_bus);
        end
        hs = data_valid && data_ready;
        if (hs) begin
          hs_cyc.push_back(cyc);
          if (exp_q.size() == 0) fail("unexpected_transfer");
          else chk("xfer", {chid_out, data_out}, exp_q.pop_front());
        end
        prev_valid = data_valid;
        prev_hs    = hs;
        prev_bus   = {chid_out, data_out};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst        = 1'b0;
    start      = 1'b0;
    data_ready = 1'b0;
    ch_mask    = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      loaded[i] = reads[i];
      m_base[i] = reads[i];
      m_seq[i]  = reads[i];
      m_cnt[i]  = 0;
    end
    exp_q.delete();
    hs_cyc.delete();
    rd_cyc.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int ch, input int n);
    loaded[ch] = loaded[ch] + n;
    m_cnt[ch]  = m_cnt[ch] + n;
  endtask

  task automatic push_lit(input int ch, input int k);
    exp_q.push_back({CHID_W'(ch), make_word(ch, m_base[ch] + k)});
  endtask

  // Transaction-level round robin: scan from ptr+1 with wrap, take up to MAX_BURST words.
  task automatic model_sched(input int first_ptr);
    int p;
    bit any;
    p = first_ptr;
    do begin
      any = 1'b0;
      for (int k = 1; k <= NUM_CH; k++) begin
        int c;
        c = (p + k) % NUM_CH;
        if (!any && ch_mask[c] && m_cnt[c] > 0) begin
          for (int b = 0; b < MAX_BURST; b++) begin
            if (m_cnt[c] > 0) begin
              exp_q.push_back({CHID_W'(c), make_word(c, m_seq[c])});
              m_seq[c] = m_seq[c] + 1;
              m_cnt[c] = m_cnt[c] - 1;
            end
          end
          p   = c;
          any = 1'b1;
        end
      end
    end while (any);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail({name, "_timeout"});
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!data_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!data_valid) fail({name, "_valid_timeout"});
  endtask

  task automatic wait_rd(input int ch, input int count, input string name);
    int n;
    int t;
    n = 0;
    t = 0;
    while (n < count && t < 200) begin
      @(negedge clk);
      t++;
      if (fifo_rd_en[ch]) n++;
    end
    if (n < count) fail({name, "_rd_timeout"});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_gap [9];
    int exp_stall;
    int exp_words;
    exp_gap = '{3, 3, 3, 4, 3, 3, 3, 4, 3};
    for (int i = 0; i < NUM_CH; i++) loaded[i] = 0;
    rst        = 1'b0;
    start      = 1'b0;
    data_ready = 1'b0;
    ch_mask    = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_en", fifo_rd_en, 0);
    chk("reset_valid", data_valid, 0);
    chk("reset_data", data_out, 0);
    chk("reset_chid", chid_out, 0);
    chk("reset_words", stat_word_cnt, 0);
    chk("reset_stalls", stat_stall_cnt, 0);

    // Single busy channel: 4-word bursts, re-granted to itself.
    do_reset();
    load(5, 10);
    data_ready = 1'b1;
    model_sched(NUM_CH - 1);
    chk("s1_model_len", exp_q.size(), 10);
    start = 1'b1;
    wait_done("s1", 600);
    repeat (5) @(posedge clk);
    #1;
    chk("s1_idle_valid", data_valid, 0);
    chk("s1_hs_count", hs_cyc.size(), 10);
    if (hs_cyc.size() == 10) begin
      for (int i = 1; i < 10; i++) chk("s1_gap", hs_cyc[i] - hs_cyc[i-1], exp_gap[i-1]);
    end
    if (rd_cyc.size() > 0 && hs_cyc.size() > 0) chk("s1_rd_to_valid", hs_cyc[0] - rd_cyc[0], 2);
`ifdef ODU_ARB_STATS_EN
    exp_words = 10;
`else
    exp_words = 0;
`endif
    chk("s1_word_cnt", stat_word_cnt, exp_words);
    chk("s1_stall_cnt", stat_stall_cnt, 0);

    // Three sparse channels: order 0, 40, 79, then idle.
    do_reset();
    load(0, 2);
    load(40, 2);
    load(79, 2);
    data_ready = 1'b1;
    model_sched(NUM_CH - 1);
    start = 1'b1;
    wait_done("s2", 600);
    repeat (20) @(posedge clk);
    #1;
    chk("s2_hs_count", hs_cyc.size(), 6);
    chk("s2_idle_valid", data_valid, 0);

    // Backpressure hold for 7 cycles.
    do_reset();
    load(2, 1);
    push_lit(2, 0);
    start = 1'b1;
    wait_valid("s3");
    repeat (7) @(posedge clk);
    #1 data_ready = 1'b1;
    wait_done("s3", 50);
    @(posedge clk);
    #1;
`ifdef ODU_ARB_STATS_EN
    exp_stall = 7;
    exp_words = 1;
`else
    exp_stall = 0;
    exp_words = 0;
`endif
    chk("s3_stall_cnt", stat_stall_cnt, exp_stall);
    chk("s3_word_cnt", stat_word_cnt, exp_words);

    // Mask cleared during the second word of channel 3.
    do_reset();
    load(3, 6);
    load(10, 2);
    data_ready = 1'b1;
    push_lit(3, 0);
    push_lit(3, 1);
    push_lit(10, 0);
    push_lit(10, 1);
    start = 1'b1;
    wait_rd(3, 2, "s4");
    @(posedge clk);
    #1 ch_mask[3] = 1'b0;
    wait_done("s4", 300);
    repeat (20) @(posedge clk);
    #1;
    chk("s4_ch3_reads", reads[3] - m_base[3], 2);
    chk("s4_ch10_reads", reads[10] - m_base[10], 2);

    // start dropped while a word waits.
    do_reset();
    load(7, 3);
    push_lit(7, 0);
    start = 1'b1;
    wait_valid("s5");
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 data_ready = 1'b1;
    wait_done("s5", 50);
    repeat (15) @(posedge clk);
    #1;
    chk("s5_ch7_reads", reads[7] - m_base[7], 1);
    chk("s5_idle_valid", data_valid, 0);

    // Asynchronous reset during CAP of channel 1's second word.
    do_reset();
    load(1, 3);
    data_ready = 1'b1;
    push_lit(1, 0);
    start = 1'b1;
    wait_rd(1, 2, "s6");
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("s6_async_rd_en", fifo_rd_en, 0);
    chk("s6_async_valid", data_valid, 0);
    chk("s6_async_data", data_out, 0);
    chk("s6_async_chid", chid_out, 0);
    chk("s6_async_words", stat_word_cnt, 0);
    chk("s6_async_stalls", stat_stall_cnt, 0);
    chk("s6_pre_reset_q", exp_q.size(), 0);
    exp_q.delete();
    load(0, 2);
    push_lit(0, 0);
    push_lit(0, 1);
    push_lit(1, 2);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    wait_done("s6", 300);
    repeat (10) @(posedge clk);
    #1;
    chk("s6_ch1_reads", reads[1] - m_base[1], 3);
    chk("s6_idle_valid", data_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/odu_chan_arb_mux.md
# odu_chan_arb_mux

Parametrised N-channel read arbiter and output mux for the ODU data generator, placed between the per-channel generator FIFOs and the single data output port. It replaces the fixed 80-channel selector with a round-robin, burst-limited scheduler that honours a per-channel enable mask and downstream valid/ready backpressure. Each transferred word is tagged with its channel ID.

## Interface
- NUM_CH, 80, number of channel FIFOs (2..128)
- DATA_W, 395, FIFO/output word width
- CHID_W, 7, channel ID width; must satisfy 2^CHID_W >= NUM_CH
- MAX_BURST, 4, maximum consecutive words per grant (1..15)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- start  in  1  level enable from the config block; 0 stops new grants
- ch_mask  in  NUM_CH  per-channel enable; bit i = 1 lets channel i be granted
- fifo_empty  in  NUM_CH  per-channel FIFO empty flags
- fifo_data  in  NUM_CH*DATA_W  flattened FIFO outputs; channel i at [i*DATA_W +: DATA_W]
- fifo_rd_en  out  NUM_CH  one-hot read strobe, at most one bit high
- data_out  out  DATA_W  registered output word
- chid_out  out  CHID_W  channel ID of data_out
- data_valid  out  1  data_out/chid_out valid
- data_ready  in  1  downstream accepts when data_valid & data_ready
- stat_word_cnt  out  32  transferred-word counter (see Configuration)
- stat_stall_cnt  out  32  backpressure-cycle counter (see Configuration)

## Operation
- Eligible channel i: ch_mask[i] & ~fifo_empty[i] & start.
- States: IDLE, ARB, RD, CAP, WAIT.
- IDLE: start=1 -> ARB.
- ARB: search from ptr+1 upward, wrap NUM_CH-1 -> 0, including ptr itself last; first eligible -> sel, burst_cnt=0, go RD. None eligible: stay ARB. start=0 -> IDLE.
- RD: fifo_rd_en[sel]=1 for exactly one cycle -> CAP.
- CAP: FIFO word (read latency 1) registered into data_out; chid_out=sel; data_valid=1; burst_cnt+1 -> WAIT.
- WAIT: hold data_out/chid_out/data_valid stable until data_valid & data_ready. On transfer: if burst_cnt < MAX_BURST and channel sel still eligible -> RD; else ptr=sel -> ARB (or IDLE if start=0).
- start falling mid-burst: current word still completes its handshake; no further RD.
- ch_mask[sel] cleared mid-burst: burst ends after the word in flight.
- fifo_empty[sel] is sampled only in ARB and at WAIT exit; never read an empty FIFO.
- Reset: state=IDLE, ptr=NUM_CH-1 (first search starts at channel 0), fifo_rd_en=0, data_out=0, chid_out=0, data_valid=0, both stat counters=0. Reset mid-operation drops any pending word; the FIFO word already read is lost.

## Timing
- ARB decision in cycle N -> fifo_rd_en[sel] high in N+1 -> data_valid high from N+3.
- Handshake in cycle M -> data_valid low in M+1; burst continuation gives fifo_rd_en in M+1 and data_valid in M+3; a new grant gives ARB in M+1 and data_valid in M+4.
- data_ready may be held high continuously; it has no combinational path to any output.
- All outputs are registered; fifo_rd_en is decoded from registered state/sel.

## Configuration
- ODU_ARB_STATS_EN defined: stat_word_cnt increments on every data_valid & data_ready; stat_stall_cnt increments on every data_valid & ~data_ready. Both saturate at 2^32-1 and are cleared only by reset.
- Not defined: both ports are tied to 0 and the counters are not synthesised. Arbitration behaviour is identical in both builds.

## Test plan
- Reset then start=1, mask all 1, only ch 5 non-empty with 10 words, ready=1 -> exactly 4 words per grant, chid_out=5 each, data_valid spacing 3 cycles within a burst; ch 5 re-granted because it is the only eligible channel.
- NUM_CH=80, ch 0, 40, 79 each with 2 words, MAX_BURST=4 -> grant order 0,40,79; pointer wraps; 6 words total; then ARB idles with data_valid=0.
- Word held with data_ready=0 for 7 cycles -> data_out/chid_out stable; stat_stall_cnt=7 with ODU_ARB_STATS_EN, 0 without.
- Clear ch_mask[3] during ch 3's second burst word -> that word completes, next grant goes to the next eligible channel, no further reads of ch 3.
- start=0 while in WAIT -> pending word transfers, then IDLE; fifo_rd_en stays 0.
- Drive rst low during CAP -> all outputs 0 asynchronously; after release the first grant goes to channel 0 when it is eligible.
